// File: rtl/axis_complex_weight_mult_if.sv
// AXI-Stream beat bundle shared by the real/imag input and output buses of the complex weight stage.
interface axis_complex_weight_mult_if #(
  parameter int DATA_WIDTH = 128
) ();
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] keep;
  logic                    last;

  modport master (output valid, data, keep, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/axis_complex_weight_mult.sv
// Per-channel complex weight multiply: (ar + j*ai) * (wr + j*wi), rounded and saturated, two-stage
// pipeline that stalls as one unit under downstream backpressure; weights swap only at frame boundaries.
module axis_complex_weight_mult #(
  parameter int SDATA_WIDTH   = 128,
  parameter int SSAMPLE_WIDTH = 16,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int MSAMPLE_WIDTH = 16
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic signed [WEIGHT_WIDTH-1:0]  weight_re,
  input  logic signed [WEIGHT_WIDTH-1:0]  weight_im,
  input  logic                            weight_load,
  axis_complex_weight_mult_if.slave       s_axis_real,
  axis_complex_weight_mult_if.slave       s_axis_imag,
  axis_complex_weight_mult_if.master      m_axis_real,
  axis_complex_weight_mult_if.master      m_axis_imag
);
  localparam int FRAC_BITS   = WEIGHT_WIDTH - 2;
  localparam int SAMPLES     = SDATA_WIDTH / SSAMPLE_WIDTH;
  localparam int MDATA_WIDTH = SAMPLES * MSAMPLE_WIDTH;
  localparam int PROD_W      = SSAMPLE_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_W       = PROD_W + 1;

  localparam logic signed [WEIGHT_WIDTH-1:0] W_ONE   = WEIGHT_WIDTH'(64'sd1 <<< FRAC_BITS);
  localparam logic signed [SUM_W-1:0]        ROUND   = SUM_W'(64'sd1 <<< (FRAC_BITS - 1));
  localparam logic signed [SUM_W-1:0]        SAT_MAX = SUM_W'((64'sd1 <<< (MSAMPLE_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0]        SAT_MIN = SUM_W'(-(64'sd1 <<< (MSAMPLE_WIDTH - 1)));

  function automatic logic [MSAMPLE_WIDTH-1:0] saturate(input logic signed [SUM_W-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[MSAMPLE_WIDTH-1:0];
    else if (x < SAT_MIN) return SAT_MIN[MSAMPLE_WIDTH-1:0];
    else                  return x[MSAMPLE_WIDTH-1:0];
  endfunction

  // Handshake and stage control
  logic run;
  logic adv;
  logic accept;
  logic v1, last1;
  logic out_valid, out_last;
  logic [MDATA_WIDTH-1:0] out_re, out_im;
  logic [MDATA_WIDTH-1:0] re_next, im_next;

  // Weight state
  logic signed [WEIGHT_WIDTH-1:0] active_re, active_im;
  logic signed [WEIGHT_WIDTH-1:0] shadow_re, shadow_im;
  logic signed [WEIGHT_WIDTH-1:0] use_re, use_im;
  logic pending, in_frame, swap;

  // Datapath
  logic signed [SSAMPLE_WIDTH-1:0] ar [SAMPLES];
  logic signed [SSAMPLE_WIDTH-1:0] ai [SAMPLES];
  logic signed [PROD_W-1:0] p_rr [SAMPLES];
  logic signed [PROD_W-1:0] p_ii [SAMPLES];
  logic signed [PROD_W-1:0] p_ri [SAMPLES];
  logic signed [PROD_W-1:0] p_ir [SAMPLES];
  logic signed [SUM_W-1:0]  re_sum [SAMPLES];
  logic signed [SUM_W-1:0]  im_sum [SAMPLES];

  // The imag bus carries the same framing as the real bus; only the real tlast is used.
  logic unused_imag_last;
  assign unused_imag_last = s_axis_imag.last;

  // run holds tready low through reset and releases it one cycle after deassertion.
  assign adv    = run & (~out_valid | (m_axis_real.ready & m_axis_imag.ready));
  assign accept = adv & s_axis_real.valid & s_axis_imag.valid;
  assign s_axis_real.ready = adv;
  assign s_axis_imag.ready = adv;

  // A pending weight is only ever applied at a frame boundary, to the first beat of the new frame.
  assign swap   = pending & ~in_frame;
  assign use_re = swap ? shadow_re : active_re;
  assign use_im = swap ? shadow_im : active_im;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run       <= 1'b0;
      active_re <= W_ONE;
      active_im <= '0;
      shadow_re <= W_ONE;
      shadow_im <= '0;
      pending   <= 1'b0;
      in_frame  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (accept) in_frame <= ~s_axis_real.last;
      if (swap) begin
        active_re <= shadow_re;
        active_im <= shadow_im;
        pending   <= 1'b0;
      end
      // A load coinciding with a swap lands in the shadow and stays pending.
      if (weight_load) begin
        shadow_re <= weight_re;
        shadow_im <= weight_im;
        pending   <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      ar[i] = s_axis_real.data[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH];
      ai[i] = s_axis_imag.data[i*SSAMPLE_WIDTH +: SSAMPLE_WIDTH];
    end
  end

  // NOTE: product registers carry no reset; their contents are only observed behind v1.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < SAMPLES; i++) begin
        p_rr[i] <= PROD_W'(ar[i]) * PROD_W'(use_re);
        p_ii[i] <= PROD_W'(ai[i]) * PROD_W'(use_im);
        p_ri[i] <= PROD_W'(ar[i]) * PROD_W'(use_im);
        p_ir[i] <= PROD_W'(ai[i]) * PROD_W'(use_re);
      end
    end
  end

  // Round half up, arithmetic shift, then clamp to the output sample range.
  always_comb begin
    re_next = '0;
    im_next = '0;
    for (int i = 0; i < SAMPLES; i++) begin
      re_sum[i] = SUM_W'(p_rr[i]) - SUM_W'(p_ii[i]) + ROUND;
      im_sum[i] = SUM_W'(p_ri[i]) + SUM_W'(p_ir[i]) + ROUND;
      re_next[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] = saturate(re_sum[i] >>> FRAC_BITS);
      im_next[i*MSAMPLE_WIDTH +: MSAMPLE_WIDTH] = saturate(im_sum[i] >>> FRAC_BITS);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1        <= 1'b0;
      last1     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else if (adv) begin
      v1        <= accept;
      last1     <= s_axis_real.last;
      out_valid <= v1;
      out_last  <= v1 & last1;
      if (v1) begin
        out_re <= re_next;
        out_im <= im_next;
      end
    end
  end

  assign m_axis_real.valid = out_valid;
  assign m_axis_imag.valid = out_valid;
  assign m_axis_real.last  = out_last;
  assign m_axis_imag.last  = out_last;
  assign m_axis_real.data  = out_re;
  assign m_axis_imag.data  = out_im;
  assign m_axis_real.keep  = {(MDATA_WIDTH/8){out_valid}};
  assign m_axis_imag.keep  = {(MDATA_WIDTH/8){out_valid}};
endmodule
